// File: rtl/fixed_point_add_arbiter.sv
// Round-robin front end that shares one 16-bit two's-complement adder between
// NUM_REQ requesters, with a registered result stage and per-requester sticky overflow.

module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         overflow_flag_o
);

    assign result_o        = a_i + b_i;
    // Same-sign operands producing a sum of the opposite sign have wrapped.
    assign overflow_flag_o = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);

endmodule

module fixed_point_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] a_bus,
    input  logic [DATA_W*NUM_REQ-1:0] b_bus,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         result,
    output logic                      res_ovf,
    output logic [ID_W-1:0]           res_id,
    output logic [NUM_REQ-1:0]        ovf_sticky,
    input  logic [NUM_REQ-1:0]        ovf_clear
);

    // Handshake: the result stage transfers on any edge with res_valid && res_ready;
    // a request k transfers on the edge where gnt[k]=1, and a new grant is only
    // offered when the output register is empty or is being drained that edge.

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               res_ovf_q, res_ovf_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [NUM_REQ-1:0] ovf_sticky_q, ovf_sticky_d;

    logic               can_accept;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] gnt_d;

    logic [DATA_W-1:0]  a_arr [NUM_REQ];
    logic [DATA_W-1:0]  b_arr [NUM_REQ];
    logic [DATA_W-1:0]  a_sel, b_sel;
    logic [DATA_W-1:0]  sum;
    logic               sum_ovf;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = a_bus[g*DATA_W +: DATA_W];
        assign b_arr[g] = b_bus[g*DATA_W +: DATA_W];
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ)) begin
            s = s - 32'(NUM_REQ);
        end
        return ID_W'(s);
    endfunction

    assign can_accept = !res_valid_q || res_ready;

    // Search from ptr upward with wrap; the first pending request wins.
    always_comb begin
        gnt_d     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_accept && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req[wrap_add(ptr_q, i)]) begin
                    grant_any = 1'b1;
                    grant_idx = wrap_add(ptr_q, i);
                end
            end
        end
        if (grant_any) begin
            gnt_d[grant_idx] = 1'b1;
        end
    end

    assign a_sel = a_arr[grant_idx];
    assign b_sel = b_arr[grant_idx];

    adder #(.W(DATA_W)) u_adder (
        .a_i             (a_sel),
        .b_i             (b_sel),
        .result_o        (sum),
        .overflow_flag_o (sum_ovf)
    );

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        result_d    = result_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;
        if (grant_any) begin
            ptr_d       = wrap_add(grant_idx, 1);
            res_valid_d = 1'b1;
            result_d    = sum;
            res_ovf_d   = sum_ovf;
            res_id_d    = grant_idx;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        // A set arriving on the same edge as a clear takes priority.
        ovf_sticky_d = (ovf_sticky_q & ~ovf_clear) | ((grant_any && sum_ovf) ? gnt_d : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            res_valid_q  <= 1'b0;
            result_q     <= '0;
            res_ovf_q    <= 1'b0;
            res_id_q     <= '0;
            ovf_sticky_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            res_valid_q  <= res_valid_d;
            result_q     <= result_d;
            res_ovf_q    <= res_ovf_d;
            res_id_q     <= res_id_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign gnt        = gnt_d;
    assign res_valid  = res_valid_q;
    assign result     = result_q;
    assign res_ovf    = res_ovf_q;
    assign res_id     = res_id_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// Bench for fixed_point_add_arbiter: table of single-request vectors plus
// hand-written sticky, round-robin, backpressure and reset sequences.

module tb_fixed_point_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 16;
  localparam int EW      = DATA_W + 1 + ID_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [DATA_W*NUM_REQ-1:0] a_bus;
  logic [DATA_W*NUM_REQ-1:0] b_bus;
  logic [NUM_REQ-1:0]        gnt;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         result;
  logic                      res_ovf;
  logic [ID_W-1:0]           res_id;
  logic [NUM_REQ-1:0]        ovf_sticky;
  logic [NUM_REQ-1:0]        ovf_clear;

  fixed_point_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .gnt        (gnt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .ovf_sticky (ovf_sticky),
    .ovf_clear  (ovf_clear)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  vec_t            tbl [8];
  logic [EW-1:0]   exp_q [$];
  int              n_vec = 0;
  int              n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    a_bus[k*DATA_W +: DATA_W] = a;
    b_bus[k*DATA_W +: DATA_W] = b;
  endtask

  task automatic push_exp(input logic [15:0] r, input logic o, input int k);
    exp_q.push_back({r, o, ID_W'(k)});
  endtask

  // One cycle: check the combinational grant, clock, then score any latched result.
  task automatic tick(input logic [NUM_REQ-1:0] exp_gnt);
    logic [EW-1:0] e;
    #1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    #1;
    if (exp_gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("result", 32'(result), 32'(e[EW-1 -: DATA_W]));
        chk("res_ovf", 32'(res_ovf), 32'(e[ID_W]));
        chk("res_id", 32'(res_id), 32'(e[ID_W-1:0]));
      end
    end
  endtask

  task automatic do_reset(input logic [NUM_REQ-1:0] req_during);
    rst = 1'b1;
    req = req_during;
    #1;
    chk("gnt_in_reset", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{k: 0, a: 16'h0100, b: 16'h0200, res: 16'h0300, ovf: 1'b0};
    tbl[1] = '{k: 1, a: 16'h7000, b: 16'h2000, res: 16'h9000, ovf: 1'b1};
    tbl[2] = '{k: 2, a: 16'hFFFF, b: 16'hFFFF, res: 16'hFFFE, ovf: 1'b0};
    tbl[3] = '{k: 2, a: 16'h8000, b: 16'h8000, res: 16'h0000, ovf: 1'b1};
    tbl[4] = '{k: 3, a: 16'h7FFF, b: 16'h0001, res: 16'h8000, ovf: 1'b1};
    tbl[5] = '{k: 0, a: 16'h8000, b: 16'hFFFF, res: 16'h7FFF, ovf: 1'b1};
    tbl[6] = '{k: 3, a: 16'h1234, b: 16'hEDCC, res: 16'h0000, ovf: 1'b0};
    tbl[7] = '{k: 1, a: 16'hC000, b: 16'hC000, res: 16'h8000, ovf: 1'b0};

    req       = '0;
    a_bus     = '0;
    b_bus     = '0;
    res_ready = 1'b1;
    ovf_clear = '0;
    rst       = 1'b1;
    @(posedge clk);
    do_reset(4'b1111);

    // table-driven single requests
    for (int i = 0; i < 8; i++) begin
      set_op(tbl[i].k, tbl[i].a, tbl[i].b);
      req = 4'(1 << tbl[i].k);
      push_exp(tbl[i].res, tbl[i].ovf, tbl[i].k);
      tick(4'(1 << tbl[i].k));
      req = '0;
      tick(4'b0000);
      chk("pop_valid_low", 32'(res_valid), 32'd0);
      chk("pop_result_hold", 32'(result), 32'(tbl[i].res));
    end
    chk("sticky_after_table", 32'(ovf_sticky), 32'b1111);

    // sticky clear, then set-and-clear on the same edge
    ovf_clear = 4'b1111;
    tick(4'b0000);
    ovf_clear = '0;
    chk("sticky_cleared", 32'(ovf_sticky), 32'd0);
    set_op(1, 16'h7000, 16'h2000);
    req = 4'b0010;
    push_exp(16'h9000, 1'b1, 1);
    tick(4'b0010);
    chk("sticky_set", 32'(ovf_sticky), 32'b0010);
    req = '0;
    ovf_clear = 4'b0010;
    tick(4'b0000);
    ovf_clear = '0;
    chk("sticky_clr1", 32'(ovf_sticky), 32'b0000);
    req = 4'b0010;
    ovf_clear = 4'b0010;
    push_exp(16'h9000, 1'b1, 1);
    tick(4'b0010);
    ovf_clear = '0;
    req = '0;
    chk("sticky_set_wins", 32'(ovf_sticky), 32'b0010);
    tick(4'b0000);

    // round robin from a fresh pointer
    do_reset(4'b0000);
    for (int k = 0; k < NUM_REQ; k++) set_op(k, 16'(k * 16 + 1), 16'h1000);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push_exp(16'(16'h1001 + (i % 4) * 16), 1'b0, i % 4);
      tick(4'(1 << (i % 4)));
    end
    req = '0;
    tick(4'b0000);

    // backpressure: ptr is 1 here
    res_ready = 1'b0;
    set_op(0, 16'h7FFF, 16'h7FFF);
    req = 4'b0001;
    push_exp(16'hFFFE, 1'b1, 0);
    tick(4'b0001);
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_result", 32'(result), 32'hFFFE);
      chk("stall_id", 32'(res_id), 32'd0);
    end
    res_ready = 1'b1;
    set_op(1, 16'h0001, 16'h0002);
    set_op(2, 16'h0010, 16'h0020);
    push_exp(16'h0003, 1'b0, 1);
    tick(4'b0010);
    req = 4'b0100;
    push_exp(16'h0030, 1'b0, 2);
    tick(4'b0100);
    chk("sticky_bp", 32'(ovf_sticky), 32'b0001);

    // reset while a result is in flight
    set_op(3, 16'h0005, 16'h0006);
    req = 4'b1111;
    push_exp(16'h000B, 1'b0, 3);
    tick(4'b1000);
    do_reset(4'b1111);
    push_exp(16'hFFFE, 1'b1, 0);
    tick(4'b0001);
    req = '0;
    tick(4'b0000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
